// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared slice width and FSM state type for the sequential CLA adder
package cla_pkg;
   localparam int SLICE_W = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cla4.sv
// rtl/cla4.sv - combinational 4-bit carry-lookahead slice, also exporting the carry into bit 3
module cla4
   import cla_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co,
   output logic               c3
);
   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      s    = p ^ c[3:0];
      co   = c[4];
      c3   = c[3];
   end
endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - add/subtract one 4-bit CLA slice per cycle, publishing the result on entry to DONE
module cla_seq_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);
   localparam int NSL = WIDTH / SLICE_W;
   localparam int IW  = $clog2(NSL);
   localparam logic [IW-1:0] LAST = IW'(NSL - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
   logic             c_q, c_d, co_q, co_d, ovf_q, ovf_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
   logic               sl_co, sl_c3;

   assign sl_a = a_q[{idx_q, 2'b00} +: SLICE_W];
   assign sl_b = b_q[{idx_q, 2'b00} +: SLICE_W];

   cla4 u_cla4 (
      .a  (sl_a),
      .b  (sl_b),
      .ci (c_q),
      .s  (sl_s),
      .co (sl_co),
      .c3 (sl_c3)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      case (state_q)
         RUN: begin
            acc_d[{idx_q, 2'b00} +: SLICE_W] = sl_s;
            c_d   = sl_co;
            idx_d = idx_q + IW'(1);
            // s/co/ovf change only here, so partial sums never leak to the outputs
            if (idx_q == LAST) begin
               state_d = DONE;
               s_d     = acc_d;
               co_d    = sl_co;
               ovf_d   = sl_c3 ^ sl_co;
            end
         end
         default: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               c_d     = sub;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         c_q     <= c_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - directed scoreboard bench for 8- and 32-bit cla_seq_adder instances
module tb_cla_seq_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst8 = 1'b1, start8 = 1'b0, sub8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, s8;
   logic       busy8, done8, co8, ovf8;

   logic        rst32 = 1'b1, start32 = 1'b0, sub32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0, s32;
   logic        busy32, done32, co32, ovf32;

   cla_seq_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8)
   );

   cla_seq_adder #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst32), .start(start32), .sub(sub32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .s(s32), .co(co32), .ovf(ovf32)
   );

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ovf;
   } exp_t;

   exp_t q8[$];
   exp_t q32[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub);
      exp_t        e;
      logic [31:0] mask, bb;
      logic [32:0] full;
      logic        sa, sb, ss;
      mask  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      bb    = (sub ? ~b : b) & mask;
      full  = {1'b0, a & mask} + {1'b0, bb} + {32'b0, sub};
      e.s   = full[31:0] & mask;
      e.co  = full[w];
      sa    = a[w-1];
      sb    = b[w-1] ^ sub;
      ss    = e.s[w-1];
      e.ovf = (sa == sb) && (ss != sa);
      return e;
   endfunction

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub);
      exp_t       e;
      logic [7:0] prev;
      int         cyc, busy_cyc;
      prev = s8;
      @(negedge clk);
      a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
      q8.push_back(model(8, {24'b0, a}, {24'b0, b}, sub));
      cyc = 0; busy_cyc = 0;
      do begin
         @(negedge clk);
         start8 = 1'b0;
         cyc++;
         if (busy8) busy_cyc++;
         if (!done8) chk("s8_hold_while_busy", {24'b0, s8}, {24'b0, prev});
      end while (!done8 && cyc < 40);
      chk("done8_seen", {31'b0, done8}, 32'd1);
      chk("lat8", cyc, 32'd3);
      chk("busy8_cycles", busy_cyc, 32'd2);
      e = q8.pop_front();
      chk("s8", {24'b0, s8}, e.s);
      chk("co8", {31'b0, co8}, {31'b0, e.co});
      chk("ovf8", {31'b0, ovf8}, {31'b0, e.ovf});
      @(negedge clk);
      chk("done8_one_cycle", {31'b0, done8}, 32'd0);
      chk("s8_hold_idle", {24'b0, s8}, e.s);
   endtask

   task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input int pulse_at);
      exp_t        e;
      logic [31:0] prev;
      int          cyc, busy_cyc, extra;
      prev = s32;
      @(negedge clk);
      a32 = a; b32 = b; sub32 = sub; start32 = 1'b1;
      q32.push_back(model(32, a, b, sub));
      cyc = 0; busy_cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == pulse_at) begin
            a32 = ~a; b32 = a ^ b; sub32 = ~sub; start32 = 1'b1;
         end else begin
            start32 = 1'b0;
         end
         if (busy32) busy_cyc++;
         if (!done32) chk("s32_hold_while_busy", s32, prev);
      end while (!done32 && cyc < 60);
      start32 = 1'b0;
      chk("done32_seen", {31'b0, done32}, 32'd1);
      chk("lat32", cyc, 32'd9);
      chk("busy32_cycles", busy_cyc, 32'd8);
      e = q32.pop_front();
      chk("s32", s32, e.s);
      chk("co32", {31'b0, co32}, {31'b0, e.co});
      chk("ovf32", {31'b0, ovf32}, {31'b0, e.ovf});
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done32) extra++;
      end
      chk("no_extra_done32", extra, 32'd0);
      chk("s32_hold_idle", s32, e.s);
   endtask

   initial begin
      exp_t e;
      int   cyc, extra;

      repeat (2) @(negedge clk);
      rst8 = 1'b0; rst32 = 1'b0;
      chk("rst_busy8", {31'b0, busy8}, 32'd0);
      chk("rst_done8", {31'b0, done8}, 32'd0);
      chk("rst_s8", {24'b0, s8}, 32'd0);
      chk("rst_co8", {31'b0, co8}, 32'd0);
      chk("rst_ovf8", {31'b0, ovf8}, 32'd0);
      chk("rst_busy32", {31'b0, busy32}, 32'd0);
      chk("rst_s32", s32, 32'd0);

      // reset wins over a simultaneous start
      rst8 = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      @(negedge clk);
      chk("rst_over_start_busy8", {31'b0, busy8}, 32'd0);
      rst8 = 1'b0; start8 = 1'b0;
      @(negedge clk);
      chk("rst_over_start_idle8", {31'b0, busy8}, 32'd0);

      op8(8'h3C, 8'h47, 1'b0);
      chk("vec1_s", {24'b0, s8}, 32'h83);
      chk("vec1_co", {31'b0, co8}, 32'd0);
      chk("vec1_ovf", {31'b0, ovf8}, 32'd1);

      op8(8'h05, 8'h07, 1'b1);
      chk("vec2_s", {24'b0, s8}, 32'hFE);
      chk("vec2_co", {31'b0, co8}, 32'd0);
      chk("vec2_ovf", {31'b0, ovf8}, 32'd0);

      op8(8'h80, 8'h01, 1'b1);
      op8(8'hFF, 8'hFF, 1'b0);
      op8(8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

      op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1);
      chk("vec3_s", s32, 32'h0);
      chk("vec3_co", {31'b0, co32}, 32'd1);
      chk("vec3_ovf", {31'b0, ovf32}, 32'd0);

      op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, -1);
      op32(32'h8000_0000, 32'h0000_0001, 1'b1, -1);

      // second start mid-RUN must not disturb the first operation
      op32(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 3);
      chk("midrun_start_s", s32, 32'h2222_2221);

      // reset during slice 3
      @(negedge clk);
      a32 = 32'hDEAD_BEEF; b32 = 32'h0101_0101; sub32 = 1'b0; start32 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start32 = 1'b0;
      end
      chk("pre_rst_busy32", {31'b0, busy32}, 32'd1);
      rst32 = 1'b1;
      @(negedge clk);
      rst32 = 1'b0;
      chk("midrst_busy32", {31'b0, busy32}, 32'd0);
      chk("midrst_done32", {31'b0, done32}, 32'd0);
      chk("midrst_s32", s32, 32'd0);
      chk("midrst_co32", {31'b0, co32}, 32'd0);
      chk("midrst_ovf32", {31'b0, ovf32}, 32'd0);
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done32) extra++;
      end
      chk("midrst_no_done32", extra, 32'd0);
      op32(32'h0000_0010, 32'h0000_0020, 1'b1, -1);

      // start held high: back-to-back operations every 3 cycles
      @(negedge clk);
      a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
      q8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, sub8));
      for (int k = 0; k < 6; k++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!done8 && cyc < 40);
         chk("b2b_lat8", cyc, 32'd3);
         e = q8.pop_front();
         chk("b2b_s8", {24'b0, s8}, e.s);
         chk("b2b_co8", {31'b0, co8}, {31'b0, e.co});
         chk("b2b_ovf8", {31'b0, ovf8}, {31'b0, e.ovf});
         if (k < 5) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            q8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, sub8));
         end else begin
            start8 = 1'b0;
         end
      end
      @(negedge clk);
      chk("b2b_end_idle8", {30'b0, busy8, done8}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
